// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared constants and EX-stage record for pipelined_datapath
package datapath_pkg;
    localparam int OP_A    = 0;
    localparam int OP_B    = 1;
    localparam int OP_C    = 2;
    localparam int OP_D    = 3;
    localparam int NUM_OPS = 4;

    localparam int WR_Y1 = 0;
    localparam int WR_Y2 = 1;

    // Destination fields are stored at a fixed width so the record is parameter-free
    localparam int MAX_AW = 8;
    typedef logic [MAX_AW-1:0] dest_t;

    typedef struct packed {
        logic       valid;
        dest_t      y1;
        dest_t      y2;
        logic [1:0] write;
    } ex_stage_t;
endpackage

// File: rtl/dp_regfile.sv
// rtl/dp_regfile.sv - NREGS x WIDTH register file, 4 async reads, 2 writes (Y2 wins), r0 auto-increment
module dp_regfile
    import datapath_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 16,
    parameter int               AW       = 4,
    parameter logic [WIDTH-1:0] PC_STEP  = 1,
    parameter logic [WIDTH-1:0] RESET_PC = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_OPS-1:0][AW-1:0]      rd_addr,
    output logic [NUM_OPS-1:0][WIDTH-1:0]   rd_data,
    input  logic [1:0]                      we,
    input  dest_t                           wr_addr1,
    input  dest_t                           wr_addr2,
    input  logic [WIDTH-1:0]                wr_data1,
    input  logic [WIDTH-1:0]                wr_data2,
    input  logic                            pc_inc,
    output logic [WIDTH-1:0]                pc
);
    logic [WIDTH-1:0] mem [NREGS];

    always_comb begin
        for (int k = 0; k < NUM_OPS; k++) begin
            rd_data[k] = mem[rd_addr[k]];
        end
    end

    // A retiring write to r0 takes precedence over the increment on the same edge
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                mem[i] <= (i == 0) ? RESET_PC : '0;
            end else if (we[WR_Y2] && wr_addr2 == dest_t'(i)) begin
                mem[i] <= wr_data2;
            end else if (we[WR_Y1] && wr_addr1 == dest_t'(i)) begin
                mem[i] <= wr_data1;
            end else if (i == 0 && pc_inc) begin
                mem[i] <= mem[i] + PC_STEP;
            end
        end
    end

    assign pc = mem[0];
endmodule

// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage issue/EX datapath; DATAPATH_BYPASS_EN selects forwarding over hazard stall
module pipelined_datapath
    import datapath_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 16,
    parameter logic [WIDTH-1:0] PC_STEP  = 1,
    parameter logic [WIDTH-1:0] RESET_PC = 0,
    localparam int              AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [AW-1:0]    iss_a,
    input  logic [AW-1:0]    iss_b,
    input  logic [AW-1:0]    iss_c,
    input  logic [AW-1:0]    iss_d,
    input  logic             iss_const_c,
    input  logic [WIDTH-1:0] iss_constant,
    input  logic             iss_pc_inc,
    input  logic [AW-1:0]    iss_y1,
    input  logic [AW-1:0]    iss_y2,
    input  logic [1:0]       iss_write,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_op_a,
    output logic [WIDTH-1:0] ex_op_b,
    output logic [WIDTH-1:0] ex_op_c,
    output logic [WIDTH-1:0] ex_op_d,
    input  logic [WIDTH-1:0] alu_y1,
    input  logic [WIDTH-1:0] alu_y2,
    input  logic             alu_busy,
    output logic [WIDTH-1:0] program_counter
);
    ex_stage_t                          ex;
    logic [NUM_OPS-1:0][WIDTH-1:0]      ex_ops;
    logic [NUM_OPS-1:0][AW-1:0]         op_addr;
    logic [NUM_OPS-1:0][WIDTH-1:0]      rf_data;
    logic [NUM_OPS-1:0][WIDTH-1:0]      op_val;
    logic                               accept;
    logic                               retire;
    logic                               hazard_stall;

    assign op_addr   = {iss_d, iss_c, iss_b, iss_a};
    assign retire    = ex.valid && !alu_busy;
    assign iss_ready = !(ex.valid && alu_busy) && !hazard_stall;
    assign accept    = iss_valid && iss_ready;

`ifdef DATAPATH_BYPASS_EN
    assign hazard_stall = 1'b0;
`else
    // Stall while any real register read targets a destination still in EX
    always_comb begin
        hazard_stall = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (ex.valid
                && !(k == OP_C && iss_const_c)
                && !(op_addr[k] == '0 && iss_pc_inc)
                && ((ex.write[WR_Y1] && ex.y1 == dest_t'(op_addr[k]))
                 || (ex.write[WR_Y2] && ex.y2 == dest_t'(op_addr[k])))) begin
                hazard_stall = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < NUM_OPS; k++) begin
            if (k == OP_C && iss_const_c) begin
                op_val[k] = iss_constant;
            end else if (op_addr[k] == '0 && iss_pc_inc) begin
                op_val[k] = '0;
`ifdef DATAPATH_BYPASS_EN
            end else if (retire && ex.write[WR_Y2] && ex.y2 == dest_t'(op_addr[k])) begin
                op_val[k] = alu_y2;
            end else if (retire && ex.write[WR_Y1] && ex.y1 == dest_t'(op_addr[k])) begin
                op_val[k] = alu_y1;
`endif
            end else begin
                op_val[k] = rf_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex     <= '0;
            ex_ops <= '0;
        end else if (accept) begin
            ex     <= '{valid: 1'b1, y1: dest_t'(iss_y1), y2: dest_t'(iss_y2), write: iss_write};
            ex_ops <= op_val;
        end else if (retire) begin
            ex.valid <= 1'b0;
        end
    end

    dp_regfile #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .AW       (AW),
        .PC_STEP  (PC_STEP),
        .RESET_PC (RESET_PC)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (op_addr),
        .rd_data  (rf_data),
        .we       (retire ? ex.write : 2'b00),
        .wr_addr1 (ex.y1),
        .wr_addr2 (ex.y2),
        .wr_data1 (alu_y1),
        .wr_data2 (alu_y2),
        .pc_inc   (accept && iss_pc_inc),
        .pc       (program_counter)
    );

    assign ex_valid = ex.valid;
    assign ex_op_a  = ex_ops[OP_A];
    assign ex_op_b  = ex_ops[OP_B];
    assign ex_op_c  = ex_ops[OP_C];
    assign ex_op_d  = ex_ops[OP_D];
endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - self-checking bench for pipelined_datapath with a cycle-level reference model
module tb_pipelined_datapath;
    localparam int          W        = 32;
    localparam int          N        = 16;
    localparam logic [31:0] STEP     = 32'd4;
    localparam logic [31:0] RST_PC   = 32'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_a, iss_b, iss_c, iss_d;
    logic        iss_const_c;
    logic [31:0] iss_constant;
    logic        iss_pc_inc;
    logic [3:0]  iss_y1, iss_y2;
    logic [1:0]  iss_write;
    logic        ex_valid;
    logic [31:0] ex_op_a, ex_op_b, ex_op_c, ex_op_d;
    logic [31:0] alu_y1, alu_y2;
    logic        alu_busy;
    logic [31:0] program_counter;

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;

    // reference model state
    logic [31:0] m_reg [N];
    logic        m_v;
    logic [3:0]  m_y1, m_y2;
    logic [1:0]  m_w;
    logic [31:0] m_op [4];

    always #5 clk = ~clk;

    pipelined_datapath #(
        .WIDTH(W), .NREGS(N), .PC_STEP(STEP), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_a(iss_a), .iss_b(iss_b), .iss_c(iss_c), .iss_d(iss_d),
        .iss_const_c(iss_const_c), .iss_constant(iss_constant), .iss_pc_inc(iss_pc_inc),
        .iss_y1(iss_y1), .iss_y2(iss_y2), .iss_write(iss_write),
        .ex_valid(ex_valid),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_op_c(ex_op_c), .ex_op_d(ex_op_d),
        .alu_y1(alu_y1), .alu_y2(alu_y2), .alu_busy(alu_busy),
        .program_counter(program_counter)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] addr_of(input int p);
        case (p)
            0: return iss_a;
            1: return iss_b;
            2: return iss_c;
            default: return iss_d;
        endcase
    endfunction

    function automatic logic reads_reg(input int p);
        return !(p == 2 && iss_const_c) && !(addr_of(p) == 4'd0 && iss_pc_inc);
    endfunction

    function automatic logic m_ready();
        logic hz = 1'b0;
`ifndef DATAPATH_BYPASS_EN
        for (int p = 0; p < 4; p++) begin
            if (m_v && reads_reg(p) &&
                ((m_w[0] && addr_of(p) == m_y1) || (m_w[1] && addr_of(p) == m_y2)))
                hz = 1'b1;
        end
`endif
        return !(m_v && alu_busy) && !hz;
    endfunction

    function automatic logic [31:0] m_operand(input int p);
        logic [3:0] a = addr_of(p);
        if (p == 2 && iss_const_c) return iss_constant;
        if (a == 4'd0 && iss_pc_inc) return 32'd0;
`ifdef DATAPATH_BYPASS_EN
        if (m_v && !alu_busy && m_w[1] && a == m_y2) return alu_y2;
        if (m_v && !alu_busy && m_w[0] && a == m_y1) return alu_y1;
`endif
        return m_reg[a];
    endfunction

    // Advance one clock: predict the next architectural state from the rules, then let the edge happen
    task automatic tick(output logic acc);
        logic [31:0] nr [N];
        logic [31:0] nop [4];
        logic        nv, ret;
        logic [3:0]  ny1, ny2;
        logic [1:0]  nw;
        nr = m_reg; nop = m_op; nv = m_v; ny1 = m_y1; ny2 = m_y2; nw = m_w;
        acc = 1'b0;
        if (rst) begin
            for (int i = 0; i < N; i++) nr[i] = 32'd0;
            nr[0] = RST_PC;
            for (int p = 0; p < 4; p++) nop[p] = 32'd0;
            nv = 1'b0; ny1 = 4'd0; ny2 = 4'd0; nw = 2'b00;
        end else begin
            acc = iss_valid && m_ready();
            ret = m_v && !alu_busy;
            if (acc) for (int p = 0; p < 4; p++) nop[p] = m_operand(p);
            if (acc && iss_pc_inc) nr[0] = m_reg[0] + STEP;
            if (ret && m_w[0]) nr[m_y1] = alu_y1;
            if (ret && m_w[1]) nr[m_y2] = alu_y2;
            if (acc) begin
                nv = 1'b1; ny1 = iss_y1; ny2 = iss_y2; nw = iss_write;
            end else if (ret) begin
                nv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_reg = nr; m_op = nop; m_v = nv; m_y1 = ny1; m_y2 = ny2; m_w = nw;
    endtask

    task automatic tick1();
        logic acc;
        tick(acc);
    endtask

    task automatic set_iss(input logic v, input logic [3:0] a, b, c, d,
                           input logic cc, input logic [31:0] k, input logic pi,
                           input logic [3:0] y1, y2, input logic [1:0] w);
        iss_valid = v; iss_a = a; iss_b = b; iss_c = c; iss_d = d;
        iss_const_c = cc; iss_constant = k; iss_pc_inc = pi;
        iss_y1 = y1; iss_y2 = y2; iss_write = w;
    endtask

    task automatic idle();
        set_iss(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 4'd0, 2'b00);
    endtask

    // Clock until the offered instruction is accepted, then drop iss_valid
    task automatic issue_wait(input string name);
        logic acc;
        for (int n = 0; n < 8; n++) begin
            tick(acc);
            if (acc) begin
                idle();
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: instruction not accepted within 8 cycles", name);
        idle();
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc_ex_valid", {31'd0, ex_valid}, {31'd0, m_v});
            chk("cyc_iss_ready", {31'd0, iss_ready}, {31'd0, m_ready()});
            chk("cyc_ex_op_a", ex_op_a, m_op[0]);
            chk("cyc_ex_op_b", ex_op_b, m_op[1]);
            chk("cyc_ex_op_c", ex_op_c, m_op[2]);
            chk("cyc_ex_op_d", ex_op_d, m_op[3]);
            chk("cyc_pc", program_counter, m_reg[0]);
        end
    end

    initial begin
        rst = 1'b1; alu_y1 = 32'd0; alu_y2 = 32'd0; alu_busy = 1'b0;
        idle();
        tick1();
        tick1();
        rst = 1'b0;
        #1;
        chk("rst_pc", program_counter, 32'd0);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
        chk("rst_ops", ex_op_a | ex_op_b | ex_op_c | ex_op_d, 32'd0);
        checking = 1'b1;

        // RAW on r3 immediately after the producer
        set_iss(1'b1, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd3, 4'd0, 2'b01);
        tick1();
        alu_y1 = 32'h1234;
        set_iss(1'b1, 4'd3, 4'd1, 4'd2, 4'd4, 1'b0, 32'd0, 1'b0, 4'd9, 4'd0, 2'b00);
        #1;
`ifdef DATAPATH_BYPASS_EN
        chk("raw_ready_bypass", {31'd0, iss_ready}, 32'd1);
`else
        chk("raw_ready_stall", {31'd0, iss_ready}, 32'd0);
`endif
        issue_wait("raw_issue");
        chk("raw_op_a", ex_op_a, 32'h1234);
        tick1();

        // Same destination on both ports: Y2 wins
        set_iss(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd5, 4'd5, 2'b11);
        tick1();
        alu_y1 = 32'hAA; alu_y2 = 32'hBB;
        set_iss(1'b1, 4'd1, 4'd5, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 4'd0, 2'b00);
        issue_wait("dual_issue");
        chk("dual_fwd_or_reg_b", ex_op_b, 32'hBB);
        tick1();
        set_iss(1'b1, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 4'd0, 2'b00);
        issue_wait("dual_reread");
        chk("dual_r5", ex_op_b, 32'hBB);

        // Back-to-back PC increments
        set_iss(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b1, 4'd0, 4'd0, 2'b00);
        tick1(); chk("pc_inc1_op", ex_op_a, 32'd0); chk("pc_inc1", program_counter, 32'd4);
        tick1(); chk("pc_inc2_op", ex_op_a, 32'd0); chk("pc_inc2", program_counter, 32'd8);
        tick1(); chk("pc_inc3_op", ex_op_a, 32'd0); chk("pc_inc3", program_counter, 32'd12);
        set_iss(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 4'd0, 2'b01);
        tick1();
        chk("pc_read_r0", ex_op_a, 32'd12);
        // EX retires a write to r0 while a pc_inc instruction is accepted
        alu_y1 = 32'h40;
        set_iss(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b1, 4'd0, 4'd0, 2'b00);
        issue_wait("pc_wr_issue");
        chk("pc_write_wins", program_counter, 32'h40);
        tick1();

        // ALU busy for two cycles
        set_iss(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'h55, 1'b0, 4'd8, 4'd0, 2'b01);
        tick1();
        chk("busy_const_c", ex_op_c, 32'h55);
        alu_busy = 1'b1; alu_y1 = 32'h77;
        set_iss(1'b1, 4'd8, 4'd0, 4'd1, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 4'd0, 2'b00);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("busy_ready", {31'd0, iss_ready}, 32'd0);
            tick1();
            chk("busy_hold_c", ex_op_c, 32'h55);
            chk("busy_hold_pc", program_counter, 32'h40);
        end
        alu_busy = 1'b0;
        issue_wait("busy_release");
        chk("busy_result", ex_op_a, 32'h77);
        tick1();

        // Reset while a write to r7 is pending
        set_iss(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd7, 4'd0, 2'b01);
        tick1();
        idle();
        alu_y1 = 32'h99; rst = 1'b1;
        tick1();
        rst = 1'b0;
        chk("rst_mid_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mid_pc", program_counter, 32'd0);
        set_iss(1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 4'd0, 2'b00);
        issue_wait("rst_mid_read");
        chk("rst_mid_r7", ex_op_a, 32'd0);
        tick1();
        tick1();

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
